bpu_predecode: RTL and testbench



---
 rtl/bpu_predecode_pkg.sv | 31 +++
 rtl/bpu_ras.sv | 80 ++++++++
 rtl/bpu_predecode.sv | 124 ++++++++++++
 tb/tb_bpu_predecode.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bpu_predecode_pkg.sv
// ============================================================================
// bpu_predecode_pkg : shared opcode, link-register and RAS-operation definitions
// Rev 1.0
// ============================================================================
`default_nettype none

package bpu_predecode_pkg;

    localparam logic [6:0] INST_JAL    = 7'b1101111;
    localparam logic [6:0] INST_JALR   = 7'b1100111;
    localparam logic [6:0] INST_TYPE_B = 7'b1100011;

    localparam logic [1:0] BHT_RST_VAL = 2'b01;

    localparam logic [4:0] LINK_REG_X1 = 5'd1;
    localparam logic [4:0] LINK_REG_X5 = 5'd5;

    typedef enum logic [1:0] {
        RAS_NONE    = 2'd0,
        RAS_PUSH    = 2'd1,
        RAS_POP     = 2'd2,
        RAS_REPLACE = 2'd3
    } ras_op_e;

    function automatic logic is_link(input logic [4:0] r);
        return (r == LINK_REG_X1) || (r == LINK_REG_X5);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bpu_ras.sv
// ============================================================================
// bpu_ras : circular return address stack with push / pop / replace / flush
// Rev 1.0
// ============================================================================
`default_nettype none

module bpu_ras
    import bpu_predecode_pkg::*;
#(
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  ras_op_e     op_i,
    input  logic        flush_i,
    input  logic [31:0] push_addr_i,
    output logic [31:0] top_o,
    output logic        empty_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

    logic [31:0]   stack_q [RAS_DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_en_d;

    // Every write lands at the new top, so the write slot is simply ptr_d.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_en_d = 1'b0;
        if (flush_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else begin
            case (op_i)
                RAS_PUSH: begin
                    ptr_d   = ptr_q + 1'b1;
                    wr_en_d = 1'b1;
                    if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
                end
                RAS_POP: begin
                    if (cnt_q != '0) begin
                        ptr_d = ptr_q - 1'b1;
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                RAS_REPLACE: begin
                    wr_en_d = 1'b1;
                    if (cnt_q == '0) begin
                        ptr_d = ptr_q + 1'b1;
                        cnt_d = 1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (wr_en_d) stack_q[ptr_d] <= push_addr_i;
        end
    end

    assign top_o   = stack_q[ptr_q];
    assign empty_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/bpu_predecode.sv
// ============================================================================
// bpu_predecode : fetch-stage pre-decode with BHT direction and RAS returns
// Rev 1.0
// ============================================================================
`default_nettype none

module bpu_predecode
    import bpu_predecode_pkg::*;
#(
    parameter int BHT_DEPTH = 64,
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        inst_valid_i,
    input  logic        flush_i,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    output logic        inst_jal_o,
    output logic        inst_jalr_o,
    output logic        inst_bxx_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_addr_o,
    output logic        ras_empty_o
);

    localparam int BHT_IW = $clog2(BHT_DEPTH);

    logic [4:0]  rd, rs1;
    logic        rd_l, rs_l;
    logic [31:0] j_imm, b_imm, seq_addr, ras_top;
    ras_op_e     ras_op, ras_op_gated;

    assign rd    = inst_i[11:7];
    assign rs1   = inst_i[19:15];
    assign rd_l  = is_link(rd);
    assign rs_l  = is_link(rs1);
    assign j_imm = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign b_imm = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

    assign inst_jal_o  = (inst_i[6:0] == INST_JAL);
    assign inst_jalr_o = (inst_i[6:0] == INST_JALR);
    assign inst_bxx_o  = (inst_i[6:0] == INST_TYPE_B);
    assign seq_addr    = inst_addr_i + 32'd4;

    always_comb begin
        ras_op = RAS_NONE;
        if (inst_jal_o) begin
            if (rd_l) ras_op = RAS_PUSH;
        end else if (inst_jalr_o) begin
            case ({rd_l, rs_l})
                2'b01:   ras_op = RAS_POP;
                2'b10:   ras_op = RAS_PUSH;
                2'b11:   ras_op = (rd == rs1) ? RAS_PUSH : RAS_REPLACE;
                default: ras_op = RAS_NONE;
            endcase
        end
    end

    assign ras_op_gated = inst_valid_i ? ras_op : RAS_NONE;

    bpu_ras #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .op_i        (ras_op_gated),
        .flush_i     (flush_i),
        .push_addr_i (seq_addr),
        .top_o       (ras_top),
        .empty_o     (ras_empty_o)
    );

    logic [1:0]        bht_q [BHT_DEPTH];
    logic [BHT_IW-1:0] rd_idx, upd_idx;
    logic [1:0]        upd_cnt, bht_upd_d;

    assign rd_idx  = inst_addr_i[BHT_IW+1:2];
    assign upd_idx = upd_pc_i[BHT_IW+1:2];
    assign upd_cnt = bht_q[upd_idx];

    always_comb begin
        bht_upd_d = upd_cnt;
        if (upd_taken_i) begin
            if (upd_cnt != 2'b11) bht_upd_d = upd_cnt + 2'b01;
        end else begin
            if (upd_cnt != 2'b00) bht_upd_d = upd_cnt - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= BHT_RST_VAL;
        end else if (upd_valid_i) begin
            bht_q[upd_idx] <= bht_upd_d;
        end
    end

    // Prediction reads the pre-update BHT value and is independent of inst_valid_i.
    always_comb begin
        pred_taken_o = 1'b0;
        pred_addr_o  = seq_addr;
        if (inst_jal_o) begin
            pred_taken_o = 1'b1;
            pred_addr_o  = inst_addr_i + j_imm;
        end else if (inst_bxx_o && bht_q[rd_idx][1]) begin
            pred_taken_o = 1'b1;
            pred_addr_o  = inst_addr_i + b_imm;
        end else if (inst_jalr_o && !ras_empty_o &&
                     (ras_op == RAS_POP || ras_op == RAS_REPLACE)) begin
            pred_taken_o = 1'b1;
            pred_addr_o  = ras_top;
        end
    end

    logic unused_upd_pc;
    assign unused_upd_pc = ^{upd_pc_i[31:BHT_IW+2], upd_pc_i[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_bpu_predecode.sv
// ============================================================================
// tb_bpu_predecode : directed self-checking bench for bpu_predecode
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bpu_predecode;

    localparam logic [31:0] BEQ  = 32'hFE000CE3;  // beq x0,x0,-8
    localparam logic [31:0] CALL = 32'h100000EF;  // jal x1,+0x100
    localparam logic [31:0] RET  = 32'h00008067;  // jalr x0,0(x1)
    localparam logic [31:0] XCHG = 32'h000280E7;  // jalr x1,0(x5)

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i, inst_addr_i, upd_pc_i;
    logic        inst_valid_i, flush_i, upd_valid_i, upd_taken_i;
    logic        inst_jal_o, inst_jalr_o, inst_bxx_o, pred_taken_o, ras_empty_o;
    logic [31:0] pred_addr_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bpu_predecode #(.BHT_DEPTH(64), .RAS_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .inst_valid_i (inst_valid_i),
        .flush_i      (flush_i),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .inst_jal_o   (inst_jal_o),
        .inst_jalr_o  (inst_jalr_o),
        .inst_bxx_o   (inst_bxx_o),
        .pred_taken_o (pred_taken_o),
        .pred_addr_o  (pred_addr_o),
        .ras_empty_o  (ras_empty_o)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  dec;    // {jal, jalr, bxx}
        logic        taken;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic [31:0] ins, input logic [31:0] pc, input logic v);
        inst_i       = ins;
        inst_addr_i  = pc;
        inst_valid_i = v;
        #1;
    endtask

    task automatic pred(input string name, input logic t, input logic [31:0] a);
        chk({name, "_taken"}, {31'd0, pred_taken_o}, {31'd0, t});
        chk({name, "_addr"}, pred_addr_o, a);
    endtask

    initial begin
        vecs[0] = '{BEQ,          32'h100,      3'b001, 1'b0, 32'h104};
        vecs[1] = '{CALL,         32'h80,       3'b100, 1'b1, 32'h180};
        vecs[2] = '{RET,          32'h200,      3'b010, 1'b0, 32'h204};
        vecs[3] = '{32'h00000013, 32'h0,        3'b000, 1'b0, 32'h4};
        vecs[4] = '{32'hFFDFF06F, 32'h0,        3'b100, 1'b1, 32'hFFFFFFFC};
        vecs[5] = '{32'h00000013, 32'hFFFFFFFC, 3'b000, 1'b0, 32'h0};
        vecs[6] = '{32'h00209863, 32'h1000,     3'b001, 1'b0, 32'h1004};
        vecs[7] = '{32'h00030067, 32'h300,      3'b010, 1'b0, 32'h304};

        rst = 1'b0; inst_i = 32'h13; inst_addr_i = 0; inst_valid_i = 0;
        flush_i = 0; upd_valid_i = 0; upd_pc_i = 0; upd_taken_i = 0;
        repeat (2) step();
        chk("reset_empty", {31'd0, ras_empty_o}, 32'd1);
        rst = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            set_inst(vecs[i].inst, vecs[i].pc, 1'b0);
            chk($sformatf("vec%0d_dec", i), {29'd0, inst_jal_o, inst_jalr_o, inst_bxx_o},
                {29'd0, vecs[i].dec});
            pred($sformatf("vec%0d", i), vecs[i].taken, vecs[i].addr);
        end

        // BHT training on index 0
        set_inst(BEQ, 32'h100, 1'b0);
        upd_valid_i = 1; upd_pc_i = 32'h100; upd_taken_i = 1;
        repeat (2) step();
        upd_valid_i = 0; #1;
        pred("bht_taken2", 1'b1, 32'hF8);
        upd_valid_i = 1;
        repeat (2) step();
        upd_taken_i = 0;
        step();
        upd_valid_i = 0; #1;
        pred("bht_sat_nt1", 1'b1, 32'hF8);

        // call / return
        set_inst(CALL, 32'h80, 1'b1);
        pred("call", 1'b1, 32'h180);
        step();
        set_inst(32'h13, 32'h84, 1'b0);
        chk("call_nonempty", {31'd0, ras_empty_o}, 32'd0);
        set_inst(RET, 32'h200, 1'b1);
        pred("ret", 1'b1, 32'h84);
        step();
        set_inst(32'h13, 32'h204, 1'b0);
        chk("ret_empty", {31'd0, ras_empty_o}, 32'd1);

        // overflow: 5 calls into a 4-deep stack
        for (int i = 1; i <= 5; i++) begin
            set_inst(CALL, 32'(i * 16), 1'b1);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            set_inst(RET, 32'h300 + 32'(i * 8), 1'b1);
            if (i < 4) pred($sformatf("ovf_ret%0d", i), 1'b1, 32'h54 - 32'(i * 16));
            else       pred("ovf_ret4", 1'b0, 32'h300 + 32'(i * 8) + 32'd4);
            step();
        end

        // flush beats a simultaneous push
        for (int i = 0; i < 2; i++) begin
            set_inst(CALL, 32'h600 + 32'(i * 4), 1'b1);
            step();
        end
        set_inst(CALL, 32'h700, 1'b1);
        flush_i = 1; #1;
        step();
        flush_i = 0;
        set_inst(32'h13, 32'h704, 1'b0);
        chk("flush_empty", {31'd0, ras_empty_o}, 32'd1);
        set_inst(RET, 32'h800, 1'b1);
        pred("flush_ret", 1'b0, 32'h804);
        step();
        set_inst(BEQ, 32'h100, 1'b0);
        pred("flush_bht", 1'b1, 32'hF8);

        // replace top: call, then jalr x1,0(x5), then ret
        set_inst(CALL, 32'h400, 1'b1);
        step();
        set_inst(XCHG, 32'h500, 1'b1);
        pred("xchg", 1'b1, 32'h404);
        step();
        set_inst(RET, 32'h600, 1'b1);
        pred("xchg_ret", 1'b1, 32'h504);
        step();
        set_inst(32'h13, 32'h604, 1'b0);
        chk("xchg_empty", {31'd0, ras_empty_o}, 32'd1);

        // same-index read and update in one cycle
        set_inst(BEQ, 32'h104, 1'b0);
        upd_valid_i = 1; upd_pc_i = 32'h104; upd_taken_i = 1; #1;
        pred("same_cyc_pre", 1'b0, 32'h108);
        step();
        upd_valid_i = 0; #1;
        pred("same_cyc_post", 1'b1, 32'hFC);

        // mid-run reset with an in-flight update and a push
        set_inst(CALL, 32'h900, 1'b1);
        upd_valid_i = 1; upd_pc_i = 32'h100; upd_taken_i = 1;
        #2 rst = 1'b0;
        #1;
        chk("rst2_empty", {31'd0, ras_empty_o}, 32'd1);
        step();
        upd_valid_i = 0; rst = 1'b1;
        set_inst(BEQ, 32'h100, 1'b0);
        pred("rst2_bht", 1'b0, 32'h104);
        chk("rst2_empty_after", {31'd0, ras_empty_o}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
